// File: rtl/fir_transient_capture.sv
// Transient-response engine: drives impulse/step stimulus into a FIR filter and captures its output.
// Optional peak-magnitude tracking is enabled by defining FIR_TRANSIENT_PEAK_DETECT_EN.
module fir_transient_capture #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned OUT_WIDTH      = 32,
  parameter int unsigned CAPTURE_DEPTH  = 256,
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned IMPULSE_CYCLES = 1,
  parameter int          AMPLITUDE      = 32767,
  localparam int unsigned AW            = $clog2(CAPTURE_DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [1:0]                  i_mode,
  input  logic signed [OUT_WIDTH-1:0] i_resp_in,
  output logic signed [DATA_WIDTH-1:0] o_stim_out,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [AW:0]                 o_capture_count,
  input  logic [AW-1:0]               i_rd_addr,
  output logic signed [OUT_WIDTH-1:0] o_rd_data,
  output logic signed [OUT_WIDTH-1:0] o_peak_val,
  output logic [AW-1:0]               o_peak_idx
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic signed [DATA_WIDTH-1:0] AMP = DATA_WIDTH'(AMPLITUDE);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  logic [1:0]                  r_mode;
  logic [SW-1:0]               r_settle;
  logic [AW-1:0]               r_k;
  logic signed [OUT_WIDTH-1:0] r_mem [CAPTURE_DEPTH];

  logic          w_start_accept;
  logic          w_last_settle;
  logic          w_last_k;
  logic [AW-1:0] w_k_next;

  assign w_start_accept = (r_state == S_IDLE) && i_start;
  assign w_last_settle  = (r_settle == SW'(SETTLE_CYCLES - 1));
  assign w_last_k       = (r_k == AW'(CAPTURE_DEPTH - 1));
  assign w_k_next       = r_k + AW'(1);

  // Stimulus level for run sample k; mode 11 behaves as impulse.
  function automatic logic signed [DATA_WIDTH-1:0] stim_at(input logic [1:0] mode,
                                                           input logic [AW-1:0] k);
    logic before_gap;
    before_gap = (32'(k) < IMPULSE_CYCLES);
    case (mode)
      2'b01:   stim_at = AMP;
      2'b10:   stim_at = (32'(k) == IMPULSE_CYCLES) ? '0 : AMP;
      default: stim_at = before_gap ? AMP : '0;
    endcase
  endfunction

  // Sequencer; stim_out is loaded one edge early so it is stable for the whole sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_mode          <= 2'b00;
      r_settle        <= '0;
      r_k             <= '0;
      o_stim_out      <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_capture_count <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_stim_out <= '0;
          if (w_start_accept) begin
            r_mode          <= i_mode;
            r_settle        <= '0;
            r_k             <= '0;
            o_capture_count <= '0;
            o_busy          <= 1'b1;
            r_state         <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_last_settle) begin
            o_stim_out <= stim_at(r_mode, '0);
            r_state    <= S_RUN;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        S_RUN: begin
          o_capture_count <= {1'b0, r_k} + (AW+1)'(1);
          if (w_last_k) begin
            o_stim_out <= '0;
            o_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_k        <= w_k_next;
            o_stim_out <= stim_at(r_mode, w_k_next);
          end
        end
        S_DONE: begin
          o_stim_out <= '0;
          o_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture RAM write; contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (r_state == S_RUN) r_mem[r_k] <= i_resp_in;
  end

  // Registered read port, returns old data on a same-cycle write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_rd_data <= '0;
    else       o_rd_data <= r_mem[i_rd_addr];
  end

`ifdef FIR_TRANSIENT_PEAK_DETECT_EN
  localparam logic signed [OUT_WIDTH-1:0] MOST_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0]        MAX_POS  = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic [OUT_WIDTH-1:0] w_abs;
  logic [OUT_WIDTH-1:0] r_peak_val;
  logic [AW-1:0]        r_peak_idx;

  always_comb begin
    w_abs = i_resp_in;
    if (i_resp_in == MOST_NEG) w_abs = MAX_POS;
    else if (i_resp_in[OUT_WIDTH-1]) w_abs = -i_resp_in;
  end

  // Strictly-greater update keeps the earliest index on ties.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else if (w_start_accept) begin
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else if ((r_state == S_RUN) && (w_abs > r_peak_val)) begin
      r_peak_val <= w_abs;
      r_peak_idx <= r_k;
    end
  end

  assign o_peak_val = r_peak_val;
  assign o_peak_idx = r_peak_idx;
`else
  assign o_peak_val = '0;
  assign o_peak_idx = '0;
`endif

endmodule

// File: tb/tb_fir_transient_capture.sv
// Randomized self-checking bench for fir_transient_capture against a cycle-indexed reference model.
module tb_fir_transient_capture;

  localparam int unsigned DW     = 16;
  localparam int unsigned OW     = 32;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned AW     = 8;
  localparam int          SETTLE = 10;
  localparam int          IMP    = 1;
  localparam int          AMP    = 32767;
  localparam int          RBW_K  = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [OW-1:0] resp_in;
  logic [DW-1:0] stim_out;
  logic          busy;
  logic          done;
  logic [AW:0]   capture_count;
  logic [AW-1:0] rd_addr;
  logic [OW-1:0] rd_data;
  logic [OW-1:0] peak_val;
  logic [AW-1:0] peak_idx;

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] mem_model [DEPTH];
  bit            mem_valid [DEPTH];
  logic [OW-1:0] run_exp   [DEPTH];

  fir_transient_capture dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_mode          (mode),
    .i_resp_in       (resp_in),
    .o_stim_out      (stim_out),
    .o_busy          (busy),
    .o_done          (done),
    .o_capture_count (capture_count),
    .i_rd_addr       (rd_addr),
    .o_rd_data       (rd_data),
    .o_peak_val      (peak_val),
    .o_peak_idx      (peak_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] model_stim(input logic [1:0] m, input int k);
    logic [DW-1:0] a;
    a = DW'(AMP);
    if (m == 2'b01) return a;
    if (m == 2'b10) return (k == IMP) ? '0 : a;
    return (k < IMP) ? a : '0;
  endfunction

  function automatic logic [OW-1:0] sext(input logic [DW-1:0] x);
    return {{(OW-DW){x[DW-1]}}, x};
  endfunction

  // Peak of |x| with the most-negative value clamped to the largest positive value.
  task automatic peak_model(output logic [OW-1:0] pv, output logic [AW-1:0] pi);
    longint best, mag;
    best = 0;
    pi   = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      mag = longint'($signed(run_exp[k]));
      if (mag < 0) mag = -mag;
      if (mag > 64'sd2147483647) mag = 64'sd2147483647;
      if (mag > best) begin
        best = mag;
        pi   = AW'(k);
      end
    end
    pv = OW'(best);
  endtask

  // kind: 0 = delayed-stimulus filter, 1 = random response, 2 = -2^31 at k=7 else 5.
  task automatic run_capture(input logic [1:0] m, input int kind, input int abort_k,
                             input bit extra_starts);
    logic [DW-1:0] prev_stim;
    logic [OW-1:0] pend, expv, pv;
    logic [AW-1:0] pi;
    bit            pend_v;
    int            k;
    pend_v    = 1'b0;
    prev_stim = stim_out;
    rd_addr   = AW'(RBW_K);
    start     = 1'b1;
    mode      = m;
    resp_in   = '0;
    for (int n = 1; n <= SETTLE + int'(DEPTH) + 2; n++) begin
      tick();
      start = 1'b0;
      mode  = 2'($urandom);
      k     = n - SETTLE - 1;
      if (pend_v) begin
        if ((k - 1) == RBW_K && mem_valid[RBW_K]) chk("rbw_old_data", rd_data, mem_model[RBW_K]);
        mem_model[k-1] = pend;
        mem_valid[k-1] = 1'b1;
        pend_v = 1'b0;
      end
      if (abort_k >= 0 && k == abort_k) begin
        rst = 1'b1;
        #1;
        chk("abort_stim", stim_out, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_count", capture_count, '0);
        chk("abort_rd_data", rd_data, '0);
        chk("abort_peak", peak_val, '0);
        tick();
        rst = 1'b0;
        return;
      end
      chk("done", done, (n == SETTLE + int'(DEPTH) + 1));
      chk("busy", busy, (n <= SETTLE + int'(DEPTH) + 1));
      if (n == 1) begin
        chk("start_count_clr", capture_count, '0);
        chk("start_peak_clr", peak_val, '0);
        chk("start_idx_clr", peak_idx, '0);
      end
      if (n <= SETTLE) chk("settle_stim", stim_out, '0);
      else if (k < int'(DEPTH)) begin
        chk("run_stim", stim_out, model_stim(m, k));
        if (k == 50) chk("mid_count", capture_count, 50);
      end else begin
        chk("post_stim", stim_out, '0);
        chk("final_count", capture_count, DEPTH);
      end
      if (n == SETTLE + int'(DEPTH) + 1) begin
`ifdef FIR_TRANSIENT_PEAK_DETECT_EN
        peak_model(pv, pi);
`else
        pv = '0;
        pi = '0;
`endif
        chk("peak_val", peak_val, pv);
        chk("peak_idx", peak_idx, pi);
      end
      // Response presented to the DUT during this cycle.
      expv = '0;
      case (kind)
        0: begin
          resp_in = sext(prev_stim);
          expv = (k >= 1) ? sext(model_stim(m, k - 1)) : '0;
        end
        1: begin
          resp_in = ($urandom_range(7) == 0) ? 32'h8000_0000 : 32'($urandom);
          expv = resp_in;
        end
        default: begin
          resp_in = (k == 7) ? 32'h8000_0000 : 32'd5;
          expv = resp_in;
        end
      endcase
      if (k >= 0 && k < int'(DEPTH)) begin
        pend   = expv;
        pend_v = 1'b1;
        run_exp[k] = expv;
      end
      prev_stim = stim_out;
      if (extra_starts && (n == 5 || n == 200 || n == SETTLE + int'(DEPTH) + 1)) start = 1'b1;
    end
    resp_in = '0;
    tick();
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic readback();
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_addr = AW'(a);
      tick();
      if (mem_valid[a]) chk("readback", rd_data, mem_model[a]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    resp_in = '0;
    rd_addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem_valid[i] = 1'b0;
    repeat (10) tick();
    chk("rst_stim", stim_out, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", capture_count, '0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_peak_val", peak_val, '0);
    chk("rst_peak_idx", peak_idx, '0);
    rst = 1'b0;
    tick();

    run_capture(2'b00, 0, -1, 1'b0);
    readback();
    run_capture(2'b01, 0, -1, 1'b0);
    readback();
    run_capture(2'b10, 0, -1, 1'b0);
    readback();
    run_capture(2'b00, 0, -1, 1'b1);
    readback();
    run_capture(2'b11, 1, -1, 1'b0);
    readback();
    run_capture(2'b00, 0, 100, 1'b0);
    tick();
    run_capture(2'b00, 0, -1, 1'b0);
    readback();
    run_capture(2'($urandom), 2, -1, 1'b0);
    readback();
    repeat (2) begin
      repeat ($urandom_range(5)) tick();
      run_capture(2'($urandom), 1, -1, 1'b0);
      readback();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
